ldpc_minsum_decoder: RTL and testbench
======================================

Name: ldpc_minsum_decoder

Overview:
Parametrised flooding offset-min-sum LDPC decoder for a binary code of any size. It replaces the fixed 6x3 decoder with the following:
- a generic parity-check matrix given as a parameter
- valid/ready handshakes in place of free-running control
- saturating fixed-point messages
- a syndrome check after every iteration, with early termination

It sits between the LLR front end and the codeword sink.

Parameters:
N, 6, codeword length (variable nodes)
M, 3, parity checks (check nodes)
WIDTH, 8, signed LLR/message width
ITER_W, 8, width of iteration counter/limit
OFFSET, 0, min-sum offset subtracted from check-node magnitudes (unsigned, < 2^(WIDTH-1))
H_MATRIX, 18'h2558B, M*N bits; bit [m*N+n]=1 means VN n connects to CN m (default rows: 0:{n0,n1,n3} 1:{n1,n2,n4} 2:{n0,n2,n5})

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  LLR frame valid
in_ready  out  1  decoder can accept a frame
llr_in  in  N*WIDTH  signed channel LLRs, n at [n*WIDTH +: WIDTH]; positive means bit 0
max_num_iter  in  ITER_W  iteration limit, sampled at acceptance
out_valid  out  1  result valid
out_ready  in  1  sink accepts result
cw_out  out  N  hard-decision codeword, bit n = VN n
iter_out  out  ITER_W  iterations performed
status  out  2  2'b01 converged (syndrome zero), 2'b10 limit reached without convergence
busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, any state, including mid-decode):
  - state goes to IDLE.
  - in_ready=1, out_valid=0, busy=0, cw_out=0, iter_out=0, status=2'b00.
  - All message, LLR and counter registers are cleared.
- FSM states: IDLE, CHECK, CN_UPD, VN_UPD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready:
    - Store the LLRs, clamping -2^(WIDTH-1) to -(2^(WIDTH-1)-1).
    - Latch max_num_iter; iter_cnt=0.
    - For every edge with H=1: v2c[m][n]=llr[n].
    - hd[n] = llr[n]<0.
    - Go to CHECK.
- CHECK: compute syndrome[m] = XOR over n of hd[n] & H[m][n].
  - Syndrome all zero: go to DONE with status 01.
  - Else if iter_cnt==max_num_iter: go to DONE with status 10.
  - Otherwise go to CN_UPD.
- CN_UPD (1 cycle), per edge:
  - c2v[m][n] = sign × mag.
  - sign = product of the signs of v2c[m][k], k!=n, H=1.
  - mag = max(min|v2c[m][k]| − OFFSET, 0).
  - A row of degree 1 gives c2v=0.
  - Non-edges are held at 0.
- VN_UPD (1 cycle):
  - app[n] = llr[n] + sum over m of c2v[m][n], computed at full width WIDTH+clog2(M+1).
  - app[n] is saturated symmetrically to ±(2^(WIDTH-1)-1).
  - v2c[m][n] = sat(app[n] − c2v[m][n]).
  - hd[n] = app[n]<0.
  - iter_cnt increments, saturating at 2^ITER_W-1.
  - Go to CHECK.
- Timing:
  - One iteration is CN_UPD, VN_UPD, CHECK: 3 cycles.
  - A clean frame gives out_valid 2 cycles after acceptance.
  - A frame converging at iteration k gives out_valid 2+3k cycles after acceptance.
- DONE:
  - out_valid=1; cw_out=hd, iter_out=iter_cnt and status are registered on entry and held stable while out_ready=0.
  - On out_ready, go to IDLE next cycle; out_valid drops.
  - in_ready is 0 in DONE, so there is no same-cycle accept/emit.
- Handshakes outside IDLE: in_valid is ignored; llr_in and max_num_iter changes have no effect once a frame is accepted.
- max_num_iter=0: channel hard decision only. Result is status 01 if the syndrome is zero, else status 10 with iter_out=0.
- Empty H row: syndrome bit always 0.
- Column with no edges: app=llr.

Decomposition:
- ldpc_pkg holds:
  - status codes CONVERGED=2'b01, MAX_ITER=2'b10
  - the FSM state enum
  - a symmetric saturation function sat_msg(value, WIDTH)
  - a sign/magnitude helper
- One sub-module, ldpc_cn_minsum (params N, WIDTH, OFFSET, ROW_MASK):
  - combinational per-row extrinsic min-sum over masked inputs
  - uses a min1/min2/index search plus an XOR of signs
  - instantiated M times via generate
- VN arithmetic, syndrome and FSM stay in the top.

Test Plan:
1. All LLRs +20, max_num_iter=5 -> out_valid 2 cycles after accept, cw_out=6'b000000, iter_out=0, status=01.
2. LLRs n0=-3, others +20, max_num_iter=5, OFFSET=0 -> iteration 1:
   - c2v to n0 = +20,+20, so app0=+37.
   - app1=+37, app3=+17, app5=+17.
   - Result: cw_out=0, iter_out=1, status=01, out_valid 5 cycles after accept.
3. Same LLRs as scenario 2, max_num_iter=0 -> cw_out=6'b000001, iter_out=0, status=10.
4. LLR n2=-128, others +127, WIDTH=8 -> n2 clamped to -127, no arithmetic wrap, all app values within ±127, result status=01 with cw_out=0.
5. Scenario 1 with out_ready held 0 for 5 cycles and in_valid pulsed in DONE:
   - Outputs stay stable and in_ready stays 0.
   - out_ready=1 returns to IDLE next cycle and in_ready rises.
6. rst_n low during CN_UPD of scenario 2 -> outputs immediately at reset values. After release, a new all-+20 frame decodes exactly as scenario 1.

Source files
------------

// File: rtl/ldpc_minsum_decoder_pkg.sv
// Shared types and arithmetic helpers for the offset-min-sum LDPC decoder.
package ldpc_pkg;

  localparam logic [1:0] CONVERGED = 2'b01;
  localparam logic [1:0] MAX_ITER  = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    CN_UPD = 3'd2,
    VN_UPD = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Symmetric clamp to +/-(2^(width-1)-1), so the most negative code never appears.
  function automatic logic signed [31:0] sat_msg(input logic signed [31:0] value, input int width);
    logic signed [31:0] lim;
    lim = (32'sd1 <<< (width - 1)) - 32'sd1;
    if (value > lim) return lim;
    if (value < -lim) return -lim;
    return value;
  endfunction

  function automatic logic [31:0] msg_mag(input logic signed [31:0] value);
    return (value < 0) ? 32'(-value) : 32'(value);
  endfunction

endpackage

// File: rtl/ldpc_minsum_decoder_cn_minsum.sv
// Combinational extrinsic offset-min-sum for one parity-check row.
module ldpc_cn_minsum
  import ldpc_pkg::*;
#(
  parameter int           N        = 6,
  parameter int           WIDTH    = 8,
  parameter int           OFFSET   = 0,
  parameter logic [N-1:0] ROW_MASK = '1
) (
  input  logic [N*WIDTH-1:0] i_v2c,
  output logic [N*WIDTH-1:0] o_c2v
);

  localparam int             DEG   = $countones(ROW_MASK);
  localparam int             IW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] OFF_W = WIDTH'(OFFSET);

  logic [WIDTH-1:0] w_mag [N];
  logic [N-1:0]     w_sgn;
  logic [WIDTH-1:0] w_min1;
  logic [WIDTH-1:0] w_min2;
  logic [IW-1:0]    w_idx;
  logic             w_sgn_all;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_in
      assign w_mag[gi] = WIDTH'(msg_mag(32'($signed(i_v2c[gi*WIDTH +: WIDTH]))));
      assign w_sgn[gi] = i_v2c[gi*WIDTH + WIDTH - 1];
    end
  endgenerate

  // Two smallest magnitudes plus the position of the smallest give every edge its extrinsic min.
  always_comb begin
    w_min1    = '1;
    w_min2    = '1;
    w_idx     = '0;
    w_sgn_all = 1'b0;
    for (int n = 0; n < N; n++) begin
      if (ROW_MASK[n]) begin
        w_sgn_all = w_sgn_all ^ w_sgn[n];
        if (w_mag[n] < w_min1) begin
          w_min2 = w_min1;
          w_min1 = w_mag[n];
          w_idx  = IW'(n);
        end else if (w_mag[n] < w_min2) begin
          w_min2 = w_mag[n];
        end
      end
    end
  end

  generate
    for (gi = 0; gi < N; gi++) begin : g_out
      if (ROW_MASK[gi] && DEG >= 2) begin : g_edge
        logic [WIDTH-1:0] w_sel;
        logic [WIDTH-1:0] w_off;
        assign w_sel = (w_idx == IW'(gi)) ? w_min2 : w_min1;
        assign w_off = (w_sel > OFF_W) ? (w_sel - OFF_W) : '0;
        assign o_c2v[gi*WIDTH +: WIDTH] = (w_sgn_all ^ w_sgn[gi]) ? -w_off : w_off;
      end else begin : g_zero
        assign o_c2v[gi*WIDTH +: WIDTH] = '0;
      end
    end
  endgenerate

endmodule

// File: rtl/ldpc_minsum_decoder.sv
// Flooding offset-min-sum LDPC decoder with syndrome-based early termination.
module ldpc_minsum_decoder
  import ldpc_pkg::*;
#(
  parameter int             N        = 6,
  parameter int             M        = 3,
  parameter int             WIDTH    = 8,
  parameter int             ITER_W   = 8,
  parameter int             OFFSET   = 0,
  parameter logic [M*N-1:0] H_MATRIX = 18'h2558B
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*WIDTH-1:0]  llr_in,
  input  logic [ITER_W-1:0]   max_num_iter,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0]        cw_out,
  output logic [ITER_W-1:0]   iter_out,
  output logic [1:0]          status,
  output logic                busy
);

  localparam int AW = WIDTH + $clog2(M + 1);

  state_t r_state;
  state_t w_state_next;

  logic [N-1:0][WIDTH-1:0]        r_llr;
  logic [M-1:0][N-1:0][WIDTH-1:0] r_v2c;
  logic [M-1:0][N-1:0][WIDTH-1:0] r_c2v;
  logic [N-1:0]                   r_hd;
  logic [ITER_W-1:0]              r_iter_cnt;
  logic [ITER_W-1:0]              r_max_iter;
  logic [N-1:0]                   r_cw;
  logic [ITER_W-1:0]              r_iter_out;
  logic [1:0]                     r_status;

  logic [N-1:0][WIDTH-1:0]        w_llr_clamp;
  logic [N-1:0]                   w_llr_hd;
  logic [M-1:0][N-1:0][WIDTH-1:0] w_v2c_init;
  logic [M-1:0][N-1:0][WIDTH-1:0] w_c2v;
  logic [M-1:0][N-1:0][WIDTH-1:0] w_v2c_upd;
  logic [N-1:0]                   w_app_hd;
  logic [M-1:0]                   w_syndrome;
  logic                           w_conv;
  logic                           w_limit;

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_llr
      assign w_llr_clamp[gi] = WIDTH'(sat_msg(32'($signed(llr_in[gi*WIDTH +: WIDTH])), WIDTH));
      assign w_llr_hd[gi]    = llr_in[gi*WIDTH + WIDTH - 1];
      for (gj = 0; gj < M; gj++) begin : g_init
        assign w_v2c_init[gj][gi] = H_MATRIX[gj*N + gi] ? w_llr_clamp[gi] : '0;
      end
    end

    for (gi = 0; gi < M; gi++) begin : g_cn
      ldpc_cn_minsum #(
        .N        (N),
        .WIDTH    (WIDTH),
        .OFFSET   (OFFSET),
        .ROW_MASK (H_MATRIX[gi*N +: N])
      ) u_cn (
        .i_v2c (r_v2c[gi]),
        .o_c2v (w_c2v[gi])
      );
      assign w_syndrome[gi] = ^(r_hd & H_MATRIX[gi*N +: N]);
    end

    // app is summed wide enough that M+1 full-scale terms cannot wrap before saturation.
    for (gi = 0; gi < N; gi++) begin : g_vn
      logic signed [AW-1:0]    w_sum;
      logic signed [WIDTH-1:0] w_app;
      always_comb begin
        w_sum = AW'($signed(r_llr[gi]));
        for (int m = 0; m < M; m++) begin
          if (H_MATRIX[m*N + gi]) w_sum = w_sum + AW'($signed(r_c2v[m][gi]));
        end
      end
      assign w_app        = WIDTH'(sat_msg(32'(w_sum), WIDTH));
      assign w_app_hd[gi] = w_app[WIDTH-1];
      for (gj = 0; gj < M; gj++) begin : g_ext
        assign w_v2c_upd[gj][gi] = H_MATRIX[gj*N + gi]
          ? WIDTH'(sat_msg(32'(w_app) - 32'($signed(r_c2v[gj][gi])), WIDTH))
          : '0;
      end
    end
  endgenerate

  assign w_conv  = ~|w_syndrome;
  assign w_limit = (r_iter_cnt == r_max_iter);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_state_next = CHECK;
      end
      CHECK:  w_state_next = (w_conv || w_limit) ? DONE : CN_UPD;
      CN_UPD: w_state_next = VN_UPD;
      VN_UPD: w_state_next = CHECK;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_llr      <= '0;
      r_v2c      <= '0;
      r_c2v      <= '0;
      r_hd       <= '0;
      r_iter_cnt <= '0;
      r_max_iter <= '0;
      r_cw       <= '0;
      r_iter_out <= '0;
      r_status   <= 2'b00;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_llr      <= w_llr_clamp;
            r_v2c      <= w_v2c_init;
            r_hd       <= w_llr_hd;
            r_max_iter <= max_num_iter;
            r_iter_cnt <= '0;
          end
        end
        CHECK: begin
          if (w_conv || w_limit) begin
            r_cw       <= r_hd;
            r_iter_out <= r_iter_cnt;
            r_status   <= w_conv ? CONVERGED : MAX_ITER;
          end
        end
        CN_UPD: r_c2v <= w_c2v;
        VN_UPD: begin
          r_v2c <= w_v2c_upd;
          r_hd  <= w_app_hd;
          if (r_iter_cnt != '1) r_iter_cnt <= r_iter_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign cw_out   = r_cw;
  assign iter_out = r_iter_out;
  assign status   = r_status;

endmodule

// File: tb/tb_ldpc_minsum_decoder.sv
// Randomized bench for ldpc_minsum_decoder against an edge-level min-sum reference model.
module tb_ldpc_minsum_decoder;

  localparam int N = 6, M = 3, WIDTH = 8, ITER_W = 8, OFFSET = 0;
  localparam logic [M*N-1:0] H = 18'h2558B;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [N*WIDTH-1:0]  llr_in = '0;
  logic [ITER_W-1:0]   max_num_iter = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [N-1:0]        cw_out;
  logic [ITER_W-1:0]   iter_out;
  logic [1:0]          status;
  logic                busy;

  ldpc_minsum_decoder #(
    .N(N), .M(M), .WIDTH(WIDTH), .ITER_W(ITER_W), .OFFSET(OFFSET), .H_MATRIX(H)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .llr_in(llr_in), .max_num_iter(max_num_iter), .out_valid(out_valid),
    .out_ready(out_ready), .cw_out(cw_out), .iter_out(iter_out),
    .status(status), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     cw;
    int     iter;
    int     st;
    longint acc;
  } exp_t;

  exp_t   exp_q[$];
  int     n_checks = 0;
  int     n_pass = 0;
  longint cyc = 0;
  logic   prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
  endtask

  function automatic bit hb(input int m, input int n);
    return H[m*N + n];
  endfunction

  function automatic int sat(input int x);
    int lim;
    lim = (1 << (WIDTH - 1)) - 1;
    if (x > lim) return lim;
    if (x < -lim) return -lim;
    return x;
  endfunction

  // Reference: straightforward per-edge extrinsic min over the other edges of each row.
  function automatic void model(input int li[N], input int maxit,
                                output int cw, output int it, output int st);
    int l[N];
    int v2c[M][N];
    int c2v[M][N];
    int hd[N];
    int app, mn, sg, deg, a, p;
    bit synd;
    for (int n = 0; n < N; n++) begin
      l[n]  = sat(li[n]);
      hd[n] = (l[n] < 0) ? 1 : 0;
      for (int m = 0; m < M; m++) v2c[m][n] = l[n];
    end
    it = 0;
    st = 0;
    while (1) begin
      synd = 0;
      for (int m = 0; m < M; m++) begin
        p = 0;
        for (int n = 0; n < N; n++) if (hb(m, n)) p ^= hd[n];
        if (p != 0) synd = 1;
      end
      if (!synd) begin st = 1; break; end
      if (it == maxit) begin st = 2; break; end
      for (int m = 0; m < M; m++) begin
        for (int n = 0; n < N; n++) begin
          c2v[m][n] = 0;
          if (hb(m, n)) begin
            mn = 1 << 30; sg = 1; deg = 0;
            for (int k = 0; k < N; k++) begin
              if (k != n && hb(m, k)) begin
                deg++;
                a = (v2c[m][k] < 0) ? -v2c[m][k] : v2c[m][k];
                if (a < mn) mn = a;
                if (v2c[m][k] < 0) sg = -sg;
              end
            end
            if (deg > 0) c2v[m][n] = sg * ((mn > OFFSET) ? (mn - OFFSET) : 0);
          end
        end
      end
      for (int n = 0; n < N; n++) begin
        app = l[n];
        for (int m = 0; m < M; m++) if (hb(m, n)) app += c2v[m][n];
        app   = sat(app);
        hd[n] = (app < 0) ? 1 : 0;
        for (int m = 0; m < M; m++) if (hb(m, n)) v2c[m][n] = sat(app - c2v[m][n]);
      end
      if (it < (1 << ITER_W) - 1) it++;
    end
    cw = 0;
    for (int n = 0; n < N; n++) cw |= hd[n] << n;
  endfunction

  // Output checker: every cycle out_valid is high, the held result must match the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", out_valid, 0);
        end else begin
          chk("cw_out", cw_out, exp_q[0].cw);
          chk("iter_out", iter_out, exp_q[0].iter);
          chk("status", status, exp_q[0].st);
          chk("in_ready_in_done", in_ready, 0);
          chk("busy_in_done", busy, 1);
          if (!prev_ov) chk("latency", cyc - exp_q[0].acc, 2 + 3 * exp_q[0].iter);
        end
      end
      prev_ov <= out_valid;
    end else begin
      prev_ov <= 1'b0;
    end
  end

  task automatic drive_llr(input int l[N]);
    for (int n = 0; n < N; n++) llr_in[n*WIDTH +: WIDTH] = WIDTH'(l[n]);
  endtask

  task automatic run_frame(input string tag, input int l[N], input int maxit,
                           input int stall, input bit pulse);
    exp_t e;
    int   cw, it, st;
    bit   got;
    model(l, maxit, cw, it, st);
    drive_llr(l);
    max_num_iter = ITER_W'(maxit);
    in_valid     = 1'b1;
    chk("in_ready_idle", in_ready, 1);
    e.cw = cw; e.iter = it; e.st = st; e.acc = cyc;
    exp_q.push_back(e);
    $display("frame %s llr=%0d,%0d,%0d,%0d,%0d,%0d maxit=%0d -> cw=%b iter=%0d status=%0d stall=%0d",
             tag, l[0], l[1], l[2], l[3], l[4], l[5], maxit, N'(cw), it, st, stall);
    @(posedge clk); #1;
    in_valid     = 1'b0;
    llr_in       = {$urandom, $urandom};
    max_num_iter = ITER_W'($urandom);
    got = 1'b0;
    for (int t = 0; t < 3 * maxit + 20; t++) begin
      if (out_valid) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("out_valid_timeout", got, 1);
    if (!got) begin
      exp_q.delete();
      return;
    end
    for (int s = 0; s < stall; s++) begin
      in_valid = pulse && (s == 1);
      if (in_valid) llr_in = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    void'(exp_q.pop_front());
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_rise", in_ready, 1);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int s1[N] = '{20, 20, 20, 20, 20, 20};
    int s2[N] = '{-3, 20, 20, 20, 20, 20};
    int s4[N] = '{127, 127, -128, 127, 127, 127};
    int r[N];
    int cw, it, st;

    // Hand-derived results that pin the reference model itself.
    model(s1, 5, cw, it, st);
    chk("model_s1_cw", cw, 0); chk("model_s1_iter", it, 0); chk("model_s1_st", st, 1);
    model(s2, 5, cw, it, st);
    chk("model_s2_cw", cw, 0); chk("model_s2_iter", it, 1); chk("model_s2_st", st, 1);
    model(s2, 0, cw, it, st);
    chk("model_s3_cw", cw, 1); chk("model_s3_iter", it, 0); chk("model_s3_st", st, 2);
    model(s4, 5, cw, it, st);
    chk("model_s4_cw", cw, 0); chk("model_s4_iter", it, 1); chk("model_s4_st", st, 1);

    #22;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cw", cw_out, 0);
    chk("rst_iter", iter_out, 0);
    chk("rst_status", status, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_frame("s1_clean", s1, 5, 0, 1'b0);
    run_frame("s2_one_iter", s2, 5, 0, 1'b0);
    run_frame("s4_clamp", s4, 5, 0, 1'b0);
    run_frame("s5_stall", s1, 5, 5, 1'b1);
    run_frame("s3_no_iter", s2, 0, 0, 1'b0);

    // Abort a decode with reset while the check-node update is in progress.
    drive_llr(s2);
    max_num_iter = 8'd5;
    in_valid     = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("busy_before_reset", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_cw", cw_out, 0);
    chk("midrst_iter", iter_out, 0);
    chk("midrst_status", status, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame("s6_after_reset", s1, 5, 0, 1'b0);

    for (int f = 0; f < 40; f++) begin
      for (int n = 0; n < N; n++) begin
        if ($urandom_range(0, 3) == 0) r[n] = -int'($urandom_range(1, 128));
        else                           r[n] = int'($urandom_range(0, 127));
      end
      run_frame($sformatf("rand%0d", f), r, int'($urandom_range(0, 6)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
